// File: rtl/carregador_pkg.sv
// Shared definitions for the program loader: FSM encoding and word geometry.
package carregador_pkg;

  localparam int unsigned BYTES_POR_PALAVRA = 4;
  localparam int unsigned DEPTH_PADRAO      = 32;

  typedef enum logic [2:0] {
    Carga    = 3'd0,
    Escrita  = 3'd1,
    Verifica = 3'd2,
    Pronto   = 3'd3,
    Erro     = 3'd4
  } estado_t;

endpackage

// File: rtl/montador_palavra.sv
// Assembles little-endian 32-bit words from a byte stream: 2-bit lane counter plus lane register.
module montador_palavra
  import carregador_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cont_q;
  logic [31:0] lanes_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      cont_q  <= '0;
      lanes_q <= '0;
    end else if (load) begin
      lanes_q[{cont_q, 3'b000} +: 8] <= byte_in;
      cont_q                         <= cont_q + 2'd1;
    end
  end

  // High when the byte being loaded completes the word.
  assign word_full = load && (cont_q == 2'(BYTES_POR_PALAVRA - 1));
  assign word      = lanes_q;

endmodule

// File: rtl/carregador_programa.sv
// Program loader: byte stream -> instruction memory words, releases the core via done.
// Optional checksum byte after the last word is enabled by defining CARREGADOR_CHECKSUM_EN.
module carregador_programa
  import carregador_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_PADRAO,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   num_instr,
  output logic              erro
);

  localparam logic [ADDR_W:0] ULTIMA_POS = (ADDR_W + 1)'(DEPTH - 1);

  estado_t         estado_q, estado_d;
  logic [ADDR_W:0] palavras_q, palavras_d;
  logic            ultimo_q, ultimo_d;
  logic            carregar;
  logic            palavra_cheia;
  logic [31:0]     palavra;

`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]      soma_q, soma_d;
`endif

  montador_palavra u_montador (
    .clk       (clk),
    .clear     (rst),
    .load      (carregar),
    .byte_in   (in_byte),
    .word      (palavra),
    .word_full (palavra_cheia)
  );

  always_comb begin
    estado_d   = estado_q;
    palavras_d = palavras_q;
    ultimo_d   = ultimo_q;
    carregar   = 1'b0;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    erro       = 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
    soma_d     = soma_q;
`endif
    unique case (estado_q)
      Carga: begin
        in_ready = 1'b1;
        if (in_valid) begin
          carregar = 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
          soma_d   = soma_q ^ in_byte;
`endif
          if (palavra_cheia) begin
            ultimo_d = in_last;
            estado_d = Escrita;
          end else if (in_last) begin
            estado_d = Erro;  // program length not a multiple of 4 bytes
          end
        end
      end
      Escrita: begin
        mem_we     = 1'b1;
        palavras_d = palavras_q + 1'b1;
        if (ultimo_q) begin
`ifdef CARREGADOR_CHECKSUM_EN
          estado_d = Verifica;
`else
          estado_d = Pronto;
`endif
        end else if (palavras_q == ULTIMA_POS) begin
          estado_d = Erro;  // memory full and the stream has not ended
        end else begin
          estado_d = Carga;
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      Verifica: begin
        in_ready = 1'b1;
        if (in_valid) begin
          estado_d = (in_byte == soma_q) ? Pronto : Erro;
        end
      end
`endif
      Pronto: begin
        done = 1'b1;
      end
      Erro: begin
        erro = 1'b1;
      end
      default: begin
        estado_d = Carga;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= Carga;
      palavras_q <= '0;
      ultimo_q   <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      soma_q     <= '0;
`endif
    end else begin
      estado_q   <= estado_d;
      palavras_q <= palavras_d;
      ultimo_q   <= ultimo_d;
`ifdef CARREGADOR_CHECKSUM_EN
      soma_q     <= soma_d;
`endif
    end
  end

  assign mem_addr  = palavras_q[ADDR_W-1:0];
  assign mem_wdata = palavra;
  assign num_instr = palavras_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa; honours CARREGADOR_CHECKSUM_EN when defined.
module tb_carregador_programa;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;

  logic        in_ready, mem_we, done, erro;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  num_instr;

  logic        in_ready2, mem_we2, done2, erro2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  num_instr2;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_low = 0;
  bit          alvo = 1'b0;
  logic [31:0] qa[$], qd[$], q2a[$], q2d[$];
  logic [7:0]  prog [8];
  logic [7:0]  soma;

  carregador_programa #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .num_instr (num_instr),
    .erro      (erro)
  );

  carregador_programa #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .in_ready  (in_ready2),
    .mem_we    (mem_we2),
    .mem_addr  (mem_addr2),
    .mem_wdata (mem_wdata2),
    .done      (done2),
    .num_instr (num_instr2),
    .erro      (erro2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor and ready-low counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        qa.push_back(32'(mem_addr));
        qd.push_back(mem_wdata);
      end
      if (mem_we2) begin
        q2a.push_back(32'(mem_addr2));
        q2d.push_back(mem_wdata2);
      end
      if (!in_ready && !done && !erro) rdy_low++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    qa.delete();
    qd.delete();
    q2a.delete();
    q2d.delete();
    rdy_low = 0;
    rst     = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b, input logic l, input bit gap);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = l;
    while (!(alvo ? in_ready2 : in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed in_ready low for %0d cycles expected accept", n);
    end
    @(negedge clk);
    in_last = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h50; prog[3] = 8'h00;
    prog[4] = 8'h33; prog[5] = 8'h05; prog[6] = 8'hB5; prog[7] = 8'h40;
    soma = 8'h00;
    for (int i = 0; i < 8; i++) soma = soma ^ prog[i];
    in_byte = 8'h00;

    // Reset values, checked while rst is still asserted.
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_num_instr", 32'(num_instr), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);

    // Two words, in_valid held high.
    do_reset();
    for (int i = 0; i < 8; i++) send(prog[i], i == 7, 1'b0);
    in_valid = 1'b0;
    chk("s1_last_we", 32'(mem_we), 32'd1);
    chk("s1_done_during_write", 32'(done), 32'd0);
    @(negedge clk);
`ifdef CARREGADOR_CHECKSUM_EN
    chk("s1_verifica_ready", 32'(in_ready), 32'd1);
    chk("s1_done_before_ck", 32'(done), 32'd0);
    send(soma, 1'b0, 1'b1);
`endif
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_num_instr", 32'(num_instr), 32'd2);
    chk("s1_nwrites", 32'(qa.size()), 32'd2);
    chk("s1_addr0", qa[0], 32'd0);
    chk("s1_data0", qd[0], 32'h00500513);
    chk("s1_addr1", qa[1], 32'd1);
    chk("s1_data1", qd[1], 32'h40B50533);
    chk("s1_ready_low_cycles", 32'(rdy_low), 32'd2);

    // Misaligned end of program.
    do_reset();
    send(8'h13, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0);
    in_valid = 1'b0;
    chk("mis_erro", 32'(erro), 32'd1);
    chk("mis_done", 32'(done), 32'd0);
    chk("mis_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mis_nwrites", 32'(qa.size()), 32'd0);
    chk("mis_erro_sticky", 32'(erro), 32'd1);

    // Overflow on the DEPTH=4 instance.
    do_reset();
    alvo = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("ovf_last_we", 32'(mem_we2), 32'd1);
    chk("ovf_last_addr", 32'(mem_addr2), 32'd3);
    @(negedge clk);
    chk("ovf_erro", 32'(erro2), 32'd1);
    chk("ovf_ready", 32'(in_ready2), 32'd0);
    chk("ovf_done", 32'(done2), 32'd0);
    chk("ovf_nwrites", 32'(q2a.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("ovf_addr", q2a[k], 32'(k));
    chk("ovf_data0", q2d[0], 32'h03020100);
    chk("ovf_data3", q2d[3], 32'h0F0E0D0C);
    alvo = 1'b0;

    // Reset in the middle of a word discards the partial bytes.
    do_reset();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    do_reset();
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    send(8'hDD, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_nwrites", 32'(qa.size()), 32'd1);
    chk("mid_addr0", qa[0], 32'd0);
    chk("mid_data0", qd[0], 32'hDDCCBBAA);
`ifndef CARREGADOR_CHECKSUM_EN
    chk("mid_done", 32'(done), 32'd1);
    chk("mid_num_instr", 32'(num_instr), 32'd1);
`endif

    // Gapped valid; the 4th byte of word 0 is followed by valid held through the write.
    do_reset();
    for (int i = 0; i < 8; i++) send(prog[i], i == 7, (i % 2) == 0);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef CARREGADOR_CHECKSUM_EN
    send(soma, 1'b0, 1'b1);
`endif
    chk("tog_nwrites", 32'(qa.size()), 32'd2);
    chk("tog_data0", qd[0], 32'h00500513);
    chk("tog_data1", qd[1], 32'h40B50533);
    chk("tog_done", 32'(done), 32'd1);
    chk("tog_num_instr", 32'(num_instr), 32'd2);

`ifdef CARREGADOR_CHECKSUM_EN
    // Wrong checksum byte.
    do_reset();
    for (int i = 0; i < 8; i++) send(prog[i], i == 7, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    send(soma ^ 8'h01, 1'b0, 1'b1);
    chk("ck_bad_erro", 32'(erro), 32'd1);
    chk("ck_bad_done", 32'(done), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
